mioc_flop_driver: RTL and testbench

//  Synchronous sequencer that drives the four control pins of one MIOC NMOS flop and reads q/qbar back.

---
 rtl/mioc_flop_driver.sv | 242 ++++++++++++++++++++++++
 tb/tb_mioc_flop_driver.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mioc_flop_driver.sv
// rtl/mioc_flop_driver.sv - command-driven pin sequencer for one MIOC NMOS flop
//
// Purpose
//   Turns one LOAD / SET / CLEAR / SAMPLE command into a timed waveform on the
//   four flop control pins. It then lets the flop outputs settle, samples the
//   synchronized q/qbar pair and returns q with an error flag.
//   Flop pin protocol:
//     in1 = set   (active high)
//     in4 = clear (active high)
//     in2 = clock (the flop captures on the falling edge)
//     in3 = D_n   (active-low data)
//
// Ports
//   clk        in   single clock
//   rst        in   synchronous reset, active high
//   cmd_valid  in   command offered
//   cmd_ready  out  block idle; a command is accepted on cmd_valid & cmd_ready
//   cmd_op     in   00=LOAD 01=SET 10=CLEAR 11=SAMPLE
//   cmd_data   in   data bit for LOAD
//   rsp_valid  out  response valid, held until rsp_ready
//   rsp_ready  in   response consumer ready
//   rsp_q      out  synchronized flop q at sample time
//   rsp_err    out  q==qbar, or q differs from the value the command should leave
//   flop_in1   out  flop set pin
//   flop_in2   out  flop clock pin
//   flop_in3   out  flop D_n pin
//   flop_in4   out  flop clear pin
//   flop_q     in   flop q (asynchronous)
//   flop_qbar  in   flop qbar (asynchronous)

`timescale 1ns/1ps

module mioc_flop_driver #(
  parameter int SETUP_CYC  = 2,
  parameter int PULSE_CYC  = 2,
  parameter int SETTLE_CYC = 3,
  parameter int CNT_W      = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic       cmd_data,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic       rsp_q,
  output logic       rsp_err,
  output logic       flop_in1,
  output logic       flop_in2,
  output logic       flop_in3,
  output logic       flop_in4,
  input  logic       flop_q,
  input  logic       flop_qbar
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_SETUP  = 3'd1;
  localparam logic [2:0] S_CLKLO  = 3'd2;
  localparam logic [2:0] S_HOLD   = 3'd3;
  localparam logic [2:0] S_ASYNC  = 3'd4;
  localparam logic [2:0] S_SETTLE = 3'd5;
  localparam logic [2:0] S_RESP   = 3'd6;

  localparam logic [1:0] OP_LOAD   = 2'b00;
  localparam logic [1:0] OP_SET    = 2'b01;
  localparam logic [1:0] OP_CLEAR  = 2'b10;
  localparam logic [1:0] OP_SAMPLE = 2'b11;

  // Terminal counts: a phase of N cycles ends when the counter reads N-1.
  localparam logic [CNT_W-1:0] SETUP_LAST  = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] PULSE_LAST  = CNT_W'(PULSE_CYC - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);

  logic [2:0]       state;
  logic [2:0]       next_state;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       op_r;
  logic             data_r;

  logic             q_s1;
  logic             q_s2;
  logic             qbar_s1;
  logic             qbar_s2;
  logic             cap_q;
  logic             cap_qbar;

  logic             accept;
  logic [1:0]       op_n;
  logic             data_n;
  logic             in1_n;
  logic             in2_n;
  logic             in3_n;
  logic             in4_n;
  logic             exp_q;
  logic             err_n;
  logic             timed_state;

  assign accept = cmd_valid & cmd_ready;

  // Command fields as they will be seen by the next state. This lets the pin
  // registers switch on the same edge as the state register.
  assign op_n   = accept ? cmd_op   : op_r;
  assign data_n = accept ? cmd_data : data_r;

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE: begin
        if (accept) begin
          case (cmd_op)
            OP_LOAD:  next_state = S_SETUP;
            OP_SET:   next_state = S_ASYNC;
            OP_CLEAR: next_state = S_ASYNC;
            default:  next_state = S_SETTLE;
          endcase
        end
      end
      S_SETUP:  if (cnt == SETUP_LAST)  next_state = S_CLKLO;
      S_CLKLO:  if (cnt == PULSE_LAST)  next_state = S_HOLD;
      S_HOLD:   next_state = S_SETTLE;
      S_ASYNC:  if (cnt == PULSE_LAST)  next_state = S_SETTLE;
      S_SETTLE: if (cnt == SETTLE_LAST) next_state = S_RESP;
      S_RESP:   if (rsp_valid && rsp_ready) next_state = S_IDLE;
      default:  next_state = S_IDLE;
    endcase
  end

  // Pin levels for the state being entered. Pins are registered from this
  // decode, so they change only on clk edges and line up with the state.
  // in3 holds ~data through SETUP, CLKLO and HOLD. It therefore cannot move
  // while in2 is low. It returns to idle only after in2 has gone high again.
  always_comb begin
    in1_n = 1'b0;
    in2_n = 1'b1;
    in3_n = 1'b1;
    in4_n = 1'b0;
    case (next_state)
      S_SETUP: begin
        in3_n = ~data_n;
      end
      S_CLKLO: begin
        in2_n = 1'b0;
        in3_n = ~data_n;
      end
      S_HOLD: begin
        in3_n = ~data_n;
      end
      S_ASYNC: begin
        // Mutually exclusive: ASYNC is entered only for SET or CLEAR.
        in1_n = (op_n == OP_SET);
        in4_n = (op_n == OP_CLEAR);
      end
      default: begin
        in1_n = 1'b0;
        in2_n = 1'b1;
        in3_n = 1'b1;
        in4_n = 1'b0;
      end
    endcase
  end

  // Value the flop should hold after the command. SAMPLE has no expectation.
  always_comb begin
    exp_q = 1'b0;
    case (op_r)
      OP_LOAD: exp_q = data_r;
      OP_SET:  exp_q = 1'b1;
      default: exp_q = 1'b0;
    endcase
  end

  assign err_n = (cap_q == cap_qbar) | ((op_r != OP_SAMPLE) & (cap_q != exp_q));

  // Only the timed phases advance the counter. IDLE and RESP keep it at zero,
  // so every phase starts counting from a known value.
  assign timed_state = (state == S_SETUP) || (state == S_CLKLO) ||
                       (state == S_ASYNC) || (state == S_SETTLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      op_r      <= OP_LOAD;
      data_r    <= 1'b0;
      q_s1      <= 1'b0;
      q_s2      <= 1'b0;
      qbar_s1   <= 1'b0;
      qbar_s2   <= 1'b0;
      cap_q     <= 1'b0;
      cap_qbar  <= 1'b0;
      flop_in1  <= 1'b0;
      flop_in2  <= 1'b1;
      flop_in3  <= 1'b1;
      flop_in4  <= 1'b0;
      cmd_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_q     <= 1'b0;
      rsp_err   <= 1'b0;
    end else begin
      state <= next_state;

      if (!timed_state || (next_state != state)) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end

      if (accept) begin
        op_r   <= cmd_op;
        data_r <= cmd_data;
      end

      // Two-stage synchronizers for the asynchronous flop outputs.
      q_s1    <= flop_q;
      q_s2    <= q_s1;
      qbar_s1 <= flop_qbar;
      qbar_s2 <= qbar_s1;

      if ((state == S_SETTLE) && (cnt == SETTLE_LAST)) begin
        cap_q    <= q_s2;
        cap_qbar <= qbar_s2;
      end

      flop_in1 <= in1_n;
      flop_in2 <= in2_n;
      flop_in3 <= in3_n;
      flop_in4 <= in4_n;

      cmd_ready <= (next_state == S_IDLE);

      // The first RESP cycle evaluates the captured pair. rsp_valid rises on
      // the following edge and drops on the edge that completes the handshake.
      rsp_valid <= (state == S_RESP) && (next_state == S_RESP);
      if ((state == S_RESP) && !rsp_valid) begin
        rsp_q   <= cap_q;
        rsp_err <= err_n;
      end
    end
  end

endmodule

// File: tb/tb_mioc_flop_driver.sv
// tb/tb_mioc_flop_driver.sv - directed self-checking bench for mioc_flop_driver

`timescale 1ns/1ps

module tb_mioc_flop_driver;

  localparam logic [1:0] OP_LOAD   = 2'b00;
  localparam logic [1:0] OP_SET    = 2'b01;
  localparam logic [1:0] OP_CLEAR  = 2'b10;
  localparam logic [1:0] OP_SAMPLE = 2'b11;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic       cmd_data;
  logic       rsp_valid;
  logic       rsp_ready;
  logic       rsp_q;
  logic       rsp_err;
  logic       flop_in1;
  logic       flop_in2;
  logic       flop_in3;
  logic       flop_in4;
  logic       flop_q;
  logic       flop_qbar;

  mioc_flop_driver dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_data  (cmd_data),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_q     (rsp_q),
    .rsp_err   (rsp_err),
    .flop_in1  (flop_in1),
    .flop_in2  (flop_in2),
    .flop_in3  (flop_in3),
    .flop_in4  (flop_in4),
    .flop_q    (flop_q),
    .flop_qbar (flop_qbar)
  );

  always #5 clk = ~clk;

  // Behavioural flop: set/clear dominate; the falling edge of in2 captures ~in3.
  logic model_q;
  logic force_en;
  logic force_val;

  always @(posedge flop_in1 or posedge flop_in4 or negedge flop_in2) begin
    if (flop_in1)      model_q = 1'b1;
    else if (flop_in4) model_q = 1'b0;
    else if (!flop_in2) model_q = ~flop_in3;
  end

  assign flop_q    = force_en ? force_val : model_q;
  assign flop_qbar = force_en ? force_val : ~model_q;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  // Pin statistics gathered over one command.
  int   in1_hi, in4_hi, in2_lo, nonidle, viol;
  logic in3_lo, prev_in2, prev_in3;

  task automatic clear_pins();
    in1_hi = 0; in4_hi = 0; in2_lo = 0; nonidle = 0; viol = 0;
    in3_lo = 1'b1; prev_in2 = 1'b1; prev_in3 = 1'b1;
  endtask

  task automatic sample_pins();
    if (flop_in1) in1_hi++;
    if (flop_in4) in4_hi++;
    if (!flop_in2) begin
      in2_lo++;
      in3_lo = flop_in3;
      if (!prev_in2 && (flop_in3 != prev_in3)) viol++;
    end
    if (flop_in1 && flop_in4) viol++;
    if (flop_in1 || !flop_in2 || !flop_in3 || flop_in4) nonidle++;
    prev_in2 = flop_in2;
    prev_in3 = flop_in3;
  endtask

  // Issue one command and wait for rsp_valid. lat counts edges from accept.
  task automatic issue(input logic [1:0] op, input logic d,
                       output logic q, output logic err, output int lat);
    int waitc;
    clear_pins();
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = d;
    waitc = 0;
    while (!cmd_ready && waitc < 20) begin
      @(negedge clk);
      waitc++;
    end
    if (waitc >= 20) check("accept_timeout", waitc, 0);
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_op    = 2'b00;
    cmd_data  = 1'b0;
    lat = 0;
    sample_pins();
    while (!rsp_valid && lat < 50) begin
      @(negedge clk);
      lat++;
      sample_pins();
    end
    q   = rsp_q;
    err = rsp_err;
  endtask

  task automatic handshake();
    rsp_ready = 1'b1;
    cmd_valid = 1'b0;
    @(negedge clk);
    rsp_ready = 1'b0;
    check("rsp_valid_drop", rsp_valid, 0);
    check("cmd_ready_back", cmd_ready, 1);
  endtask

  logic q, err;
  int   lat, cnt;

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_data = 1'b0;
    rsp_ready = 1'b0; force_en = 1'b0; force_val = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_q", rsp_q, 0);
    check("rst_rsp_err", rsp_err, 0);
    check("rst_in1", flop_in1, 0);
    check("rst_in2", flop_in2, 1);
    check("rst_in3", flop_in3, 1);
    check("rst_in4", flop_in4, 0);
    model_q = 1'b1;
    rst = 1'b0;

    // 1: SAMPLE reads the flop without touching the pins.
    issue(OP_SAMPLE, 1'b0, q, err, lat);
    check("sample_lat", lat, 4);
    check("sample_q", q, 1);
    check("sample_err", err, 0);
    check("sample_pins_idle", nonidle, 0);
    handshake();

    // 2: LOAD 1 then LOAD 0.
    issue(OP_LOAD, 1'b1, q, err, lat);
    check("load1_lat", lat, 9);
    check("load1_q", q, 1);
    check("load1_err", err, 0);
    check("load1_in2_lo", in2_lo, 2);
    check("load1_in3", in3_lo, 0);
    check("load1_viol", viol, 0);
    handshake();
    issue(OP_LOAD, 1'b0, q, err, lat);
    check("load0_lat", lat, 9);
    check("load0_q", q, 0);
    check("load0_err", err, 0);
    check("load0_in2_lo", in2_lo, 2);
    check("load0_in3", in3_lo, 1);
    check("load0_viol", viol, 0);
    handshake();

    // 3: SET then CLEAR.
    issue(OP_SET, 1'b0, q, err, lat);
    check("set_lat", lat, 6);
    check("set_q", q, 1);
    check("set_err", err, 0);
    check("set_in1_hi", in1_hi, 2);
    check("set_in4_hi", in4_hi, 0);
    handshake();
    issue(OP_CLEAR, 1'b0, q, err, lat);
    check("clr_lat", lat, 6);
    check("clr_q", q, 0);
    check("clr_err", err, 0);
    check("clr_in4_hi", in4_hi, 2);
    check("clr_in1_hi", in1_hi, 0);
    check("clr_viol", viol, 0);
    handshake();

    // 4: q and qbar stuck high together.
    force_en = 1'b1; force_val = 1'b1;
    issue(OP_LOAD, 1'b0, q, err, lat);
    check("stuck_q", q, 1);
    check("stuck_err", err, 1);
    handshake();
    force_en = 1'b0;

    // 5: response stalled 5 cycles while a new command is offered.
    issue(OP_SET, 1'b0, q, err, lat);
    check("stall_first_q", q, 1);
    for (int k = 0; k < 5; k++) begin
      cmd_valid = 1'b1;
      cmd_op    = OP_CLEAR;
      @(negedge clk);
      sample_pins();
      check("stall_rsp_valid", rsp_valid, 1);
      check("stall_rsp_q", rsp_q, 1);
      check("stall_cmd_ready", cmd_ready, 0);
    end
    handshake();
    check("stall_no_clear", in4_hi, 0);
    check("stall_in4_idle", flop_in4, 0);

    // 6: reset during the low clock phase of a LOAD.
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = OP_LOAD; cmd_data = 1'b0;
    @(negedge clk);
    cmd_valid = 1'b0;
    cnt = 0;
    while (flop_in2 && cnt < 20) begin
      @(negedge clk);
      cnt++;
    end
    check("abort_in2_lo", flop_in2, 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_in2", flop_in2, 1);
    check("abort_in3", flop_in3, 1);
    check("abort_cmd_ready", cmd_ready, 1);
    check("abort_rsp_valid", rsp_valid, 0);
    cnt = 0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (rsp_valid) cnt++;
    end
    check("abort_no_rsp", cnt, 0);

    // The aborted LOAD 0 did clock the flop, so it now reads back 0.
    issue(OP_SAMPLE, 1'b0, q, err, lat);
    check("post_sample_q", q, 0);
    check("post_sample_err", err, 0);
    handshake();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
